// File: rtl/uart_pkg.sv
// UART TX shared definitions.
// State encoding, parity type codes and idle line level.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_reader_if.sv
// Read side of the TX async FIFO.
// Show-ahead head word, empty flag and pop strobe.
interface uart_tx_fifo_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  EMPTY;
  logic [DATA_WIDTH-1:0] RD_DATA;
  logic                  R_INC;

  modport master (
    input  EMPTY,
    input  RD_DATA,
    output R_INC
  );

  modport slave (
    output EMPTY,
    output RD_DATA,
    input  R_INC
  );
endinterface

// File: rtl/uart_tx_parity_calc.sv
// Frame parity register, captured when a byte is loaded.
// Holds its value until the next load so PARITY sees a stable bit.
module uart_tx_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  // capture parity of the incoming byte, inverted for odd parity
  always_ff @(posedge CLK) begin
    if (RST) begin
      parity <= 1'b0;
    end else if (load) begin
      parity <= (^data) ^ (par_typ == PAR_ODD);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter draining the TX async FIFO.
// One bit per TX_CLK cycle: start, data LSB first, parity, stop.
module uart_tx_fifo_reader
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_fifo_reader_if.master fifo,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic SB_LAST = 1'(STOP_BITS - 1);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n;
  logic [CW-1:0]         bit_cnt, bit_n;
  logic                  stop_cnt, stop_n;
  logic                  par_en_q, par_en_n;
  logic                  tx_n, rinc_q, rinc_n, busy_n;
  logic                  load, parity;

  assign fifo.R_INC = rinc_q;

  uart_tx_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_par (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .data   (fifo.RD_DATA),
    .par_typ(PAR_TYP),
    .parity (parity)
  );

  // next-state and next-output decode; every output is registered
  always_comb begin
    state_n  = state;
    shift_n  = shift_reg;
    bit_n    = bit_cnt;
    stop_n   = stop_cnt;
    par_en_n = par_en_q;
    tx_n     = TX_OUT;
    rinc_n   = 1'b0;
    busy_n   = BUSY;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_n = IDLE_LEVEL;
        if (!fifo.EMPTY) load = 1'b1;
      end
      START: begin
        state_n = DATA;
        tx_n    = shift_reg[0];
        shift_n = shift_reg >> 1;
        bit_n   = '0;
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          stop_n = 1'b0;
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = parity;
          end else begin
            state_n = STOP;
            tx_n    = IDLE_LEVEL;
          end
        end else begin
          bit_n   = bit_cnt + 1'b1;
          tx_n    = shift_reg[0];
          shift_n = shift_reg >> 1;
        end
      end
      PARITY: begin
        state_n = STOP;
        tx_n    = IDLE_LEVEL;
        stop_n  = 1'b0;
      end
      STOP: begin
        if (stop_cnt == SB_LAST) begin
          if (!fifo.EMPTY) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end else begin
          stop_n = stop_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      shift_n  = fifo.RD_DATA;
      par_en_n = PAR_EN;
      rinc_n   = 1'b1;
      tx_n     = 1'b0;
      busy_n   = 1'b1;
      state_n  = START;
    end
  end

  // state, datapath and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      par_en_q  <= 1'b0;
      TX_OUT    <= IDLE_LEVEL;
      rinc_q    <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_n;
      stop_cnt  <= stop_n;
      par_en_q  <= par_en_n;
      TX_OUT    <= tx_n;
      rinc_q    <= rinc_n;
      BUSY      <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Testbench for uart_tx_fifo_reader.
// Two instances: one with one stop bit, one with two.
module tb_uart_tx_fifo_reader;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic par_en = 1'b0;
  logic par_typ = 1'b0;
  logic tx1, busy1, tx2, busy2;

  int errors = 0;
  int checks = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] in_bytes[$];
  bit exp_tx[$], exp_rinc[$], exp_busy[$];
  bit obs_tx[$], obs_rinc[$], obs_busy[$];

  uart_tx_fifo_reader_if #(.DATA_WIDTH(8)) f1 ();
  uart_tx_fifo_reader_if #(.DATA_WIDTH(8)) f2 ();

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
    .CLK(CLK), .RST(RST), .fifo(f1.master),
    .PAR_EN(par_en), .PAR_TYP(par_typ),
    .TX_OUT(tx1), .BUSY(busy1)
  );

  uart_tx_fifo_reader #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
    .CLK(CLK), .RST(RST), .fifo(f2.master),
    .PAR_EN(par_en), .PAR_TYP(par_typ),
    .TX_OUT(tx2), .BUSY(busy2)
  );

  always #5 CLK = ~CLK;

  task automatic upd();
    f1.EMPTY = (q1.size() == 0);
    f1.RD_DATA = (q1.size() != 0) ? q1[0] : 8'h00;
    f2.EMPTY = (q2.size() == 0);
    f2.RD_DATA = (q2.size() != 0) ? q2[0] : 8'h00;
  endtask

  task automatic push(input int sel, input logic [7:0] b);
    if (sel == 0) q1.push_back(b);
    else q2.push_back(b);
    upd();
  endtask

  // one clock; FIFO model pops on an edge where R_INC was high
  task automatic tick();
    logic r1, r2;
    r1 = f1.R_INC;
    r2 = f2.R_INC;
    @(posedge CLK);
    if (r1) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL underflow1 got R_INC=1 want 0 on empty");
      end else void'(q1.pop_front());
    end
    if (r2) begin
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL underflow2 got R_INC=1 want 0 on empty");
      end else void'(q2.pop_front());
    end
    #1;
    upd();
  endtask

  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      obs_tx.push_back(sel ? tx2 : tx1);
      obs_rinc.push_back(sel ? f2.R_INC : f1.R_INC);
      obs_busy.push_back(sel ? busy2 : busy1);
    end
  endtask

  // reference line trace: frames back to back, then one idle cycle
  function automatic void build_exp(input int sb, input bit pe, input bit pt);
    exp_tx.delete();
    exp_rinc.delete();
    exp_busy.delete();
    obs_tx.delete();
    obs_rinc.delete();
    obs_busy.delete();
    foreach (in_bytes[k]) begin
      logic [7:0] b;
      int ones;
      b = in_bytes[k];
      ones = $countones(b);
      exp_tx.push_back(0); exp_rinc.push_back(1); exp_busy.push_back(1);
      for (int i = 0; i < 8; i++) begin
        exp_tx.push_back(b[i]); exp_rinc.push_back(0); exp_busy.push_back(1);
      end
      if (pe) begin
        exp_tx.push_back(bit'((ones + int'(pt)) % 2));
        exp_rinc.push_back(0); exp_busy.push_back(1);
      end
      for (int i = 0; i < sb; i++) begin
        exp_tx.push_back(1); exp_rinc.push_back(0); exp_busy.push_back(1);
      end
    end
    exp_tx.push_back(1); exp_rinc.push_back(0); exp_busy.push_back(0);
  endfunction

  task automatic test_reset();
    if ({tx1, f1.R_INC, busy1} !== 3'b100) begin
      errors++;
      $display("FAIL reset1 got %b%b%b want 100", tx1, f1.R_INC, busy1);
    end
    checks++;
    if ({tx2, f2.R_INC, busy2} !== 3'b100) begin
      errors++;
      $display("FAIL reset2 got %b%b%b want 100", tx2, f2.R_INC, busy2);
    end
    checks++;
  endtask

  task automatic test_a5(input bit pe, input bit pt);
    in_bytes = '{8'hA5};
    par_en = pe;
    par_typ = pt;
    build_exp(1, pe, pt);
    push(0, 8'hA5);
    capture(0, exp_tx.size());
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if ({obs_tx[i], obs_rinc[i], obs_busy[i]} !==
          {exp_tx[i], exp_rinc[i], exp_busy[i]}) begin
        errors++;
        $display("FAIL a5 pe=%0d pt=%0d cyc%0d got %b%b%b want %b%b%b",
          pe, pt, i, obs_tx[i], obs_rinc[i], obs_busy[i],
          exp_tx[i], exp_rinc[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    int busy_cnt;
    in_bytes = '{8'h01, 8'hFF};
    par_en = 0;
    par_typ = 0;
    build_exp(1, 0, 0);
    push(0, 8'h01);
    push(0, 8'hFF);
    capture(0, exp_tx.size());
    pulses = 0;
    busy_cnt = 0;
    for (int i = 0; i < exp_tx.size(); i++) begin
      pulses += int'(obs_rinc[i]);
      if (i < 20) busy_cnt += int'(obs_busy[i]);
      checks++;
      if ({obs_tx[i], obs_rinc[i], obs_busy[i]} !==
          {exp_tx[i], exp_rinc[i], exp_busy[i]}) begin
        errors++;
        $display("FAIL b2b cyc%0d got %b%b%b want %b%b%b", i,
          obs_tx[i], obs_rinc[i], obs_busy[i],
          exp_tx[i], exp_rinc[i], exp_busy[i]);
      end
    end
    checks++;
    if (pulses != 2) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 2", pulses);
    end
    checks++;
    if (busy_cnt != 20) begin
      errors++;
      $display("FAIL b2b_busy got %0d want 20", busy_cnt);
    end
  endtask

  task automatic test_empty_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if ({tx1, f1.R_INC, busy1} !== 3'b100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL empty_idle got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    push(0, 8'h3C);
    repeat (5) tick();
    checks++;
    if ({tx1, busy1} !== 2'b11) begin
      errors++;
      $display("FAIL mid_bit3 got %b%b want 11", tx1, busy1);
    end
    RST = 1;
    tick();
    checks++;
    if ({tx1, f1.R_INC, busy1} !== 3'b100) begin
      errors++;
      $display("FAIL mid_rst got %b%b%b want 100", tx1, f1.R_INC, busy1);
    end
    checks++;
    if (dut1.state !== uart_pkg::IDLE) begin
      errors++;
      $display("FAIL mid_state got %0d want 0", dut1.state);
    end
    RST = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({tx1, f1.R_INC, busy1} !== 3'b100) begin
        errors++;
        $display("FAIL post_rst cyc%0d got %b%b%b want 100",
          i, tx1, f1.R_INC, busy1);
      end
    end
  endtask

  task automatic test_two_stop();
    in_bytes = '{8'h00};
    par_en = 1;
    par_typ = 1;
    build_exp(2, 1, 1);
    push(1, 8'h00);
    capture(1, exp_tx.size());
    checks++;
    if (exp_tx.size() != 13) begin
      errors++;
      $display("FAIL two_stop_len got %0d want 13", exp_tx.size());
    end
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if ({obs_tx[i], obs_rinc[i], obs_busy[i]} !==
          {exp_tx[i], exp_rinc[i], exp_busy[i]}) begin
        errors++;
        $display("FAIL two_stop cyc%0d got %b%b%b want %b%b%b", i,
          obs_tx[i], obs_rinc[i], obs_busy[i],
          exp_tx[i], exp_rinc[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_config_latch();
    in_bytes = '{8'hA5};
    par_en = 1;
    par_typ = 0;
    build_exp(1, 1, 0);
    push(0, 8'hA5);
    capture(0, 3);
    par_en = 0;
    par_typ = 1;
    capture(0, exp_tx.size() - 3);
    for (int i = 0; i < exp_tx.size(); i++) begin
      checks++;
      if ({obs_tx[i], obs_rinc[i], obs_busy[i]} !==
          {exp_tx[i], exp_rinc[i], exp_busy[i]}) begin
        errors++;
        $display("FAIL cfg_latch cyc%0d got %b%b%b want %b%b%b", i,
          obs_tx[i], obs_rinc[i], obs_busy[i],
          exp_tx[i], exp_rinc[i], exp_busy[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int sel;
      int n;
      bit pe, pt;
      sel = it % 2;
      n = $urandom_range(1, 3);
      pe = bit'($urandom_range(0, 1));
      pt = bit'($urandom_range(0, 1));
      par_en = pe;
      par_typ = pt;
      in_bytes.delete();
      for (int k = 0; k < n; k++) in_bytes.push_back(8'($urandom));
      build_exp(sel ? 2 : 1, pe, pt);
      foreach (in_bytes[k]) push(sel, in_bytes[k]);
      capture(sel, exp_tx.size());
      for (int i = 0; i < exp_tx.size(); i++) begin
        checks++;
        if ({obs_tx[i], obs_rinc[i], obs_busy[i]} !==
            {exp_tx[i], exp_rinc[i], exp_busy[i]}) begin
          errors++;
          $display("FAIL rand it%0d cyc%0d got %b%b%b want %b%b%b", it, i,
            obs_tx[i], obs_rinc[i], obs_busy[i],
            exp_tx[i], exp_rinc[i], exp_busy[i]);
        end
      end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  initial begin
    upd();
    repeat (2) @(posedge CLK);
    #1;
    test_reset();
    RST = 0;
    tick();
    test_a5(0, 0);
    test_a5(1, 0);
    test_a5(1, 1);
    test_back_to_back();
    test_empty_idle();
    test_mid_reset();
    test_two_stop();
    test_config_latch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
